hicore_lsu: RTL and testbench

HICORE_LSU -- requirements
Module: HiCore_lsu

---
 rtl/hicore_lsu_pkg.sv | 30 +++
 rtl/hicore_lsu_align.sv | 27 ++
 rtl/hicore_lsu.sv | 138 +++++++++++++
 tb/tb_hicore_lsu.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hicore_lsu_pkg.sv
// Shared definitions for the HiCore load/store unit: widths, FSM encoding,
// access sizes and the exception cause bit positions inside the info bundle.
package hicore_lsu_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;
  localparam int INFO_W_DEF = 64;
  localparam int EXCP_W_DEF = 16;

  // Exception cause bits within the low EXCP_W bits of the info bundle.
  localparam int EXCP_LD_MISALIGN = 4;
  localparam int EXCP_LD_FAULT    = 5;
  localparam int EXCP_ST_MISALIGN = 6;
  localparam int EXCP_ST_FAULT    = 7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_RSP   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_WB    = 3'd4
  } lsu_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_SHORT = 2'd1,
    SZ_WORD  = 2'd2
  } lsu_size_e;

endpackage

// File: rtl/hicore_lsu_align.sv
// Load data extraction: moves the addressed byte/short down to bit 0 of the
// aligned bus word and sign- or zero-extends it; words pass through.
module hicore_lsu_align
  import hicore_lsu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        addr_lo,
  input  lsu_size_e         size,
  input  logic              is_unsigned,
  output logic [DATA_W-1:0] data
);

  logic [DATA_W-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    data    = rdata;
    case (size)
      SZ_BYTE:  data = {{(DATA_W-8){~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_SHORT: data = {{(DATA_W-16){~is_unsigned & shifted[15]}}, shifted[15:0]};
      default:  data = rdata;
    endcase
  end

endmodule

// File: rtl/hicore_lsu.sv
// HiCore load/store unit: one access in flight, AGU request -> bus command ->
// bus response -> writeback, with commit flush and a drain state for orphans.
module hicore_lsu
  import hicore_lsu_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int INFO_W = INFO_W_DEF,
  parameter int EXCP_W = EXCP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                agu2lsu_valid,
  output logic                agu2lsu_ready,
  input  logic                agu2lsu_cancel,
  input  logic                agu2lsu_read,
  input  logic                agu2lsu_unsigned,
  input  logic                agu2lsu_word_access,
  input  logic                agu2lsu_short_access,
  input  logic                agu2lsu_byte_access,
  input  logic [ADDR_W-1:0]   agu2lsu_addr,
  input  logic [DATA_W-1:0]   agu2lsu_wdata,
  input  logic [DATA_W/8-1:0] agu2lsu_wmask,
  input  logic [INFO_W-1:0]   agu2lsu_info,
  output logic                bus_cmd_valid,
  input  logic                bus_cmd_ready,
  output logic                bus_cmd_read,
  output logic [ADDR_W-1:0]   bus_cmd_addr,
  output logic [DATA_W-1:0]   bus_cmd_wdata,
  output logic [DATA_W/8-1:0] bus_cmd_wmask,
  input  logic                bus_rsp_valid,
  input  logic                bus_rsp_err,
  input  logic [DATA_W-1:0]   bus_rsp_rdata,
  output logic                lsu2wb_valid,
  input  logic                lsu2wb_ready,
  output logic [DATA_W-1:0]   lsu2wb_data,
  output logic [INFO_W-1:0]   lsu2wb_info,
  input  logic                flush,
  output logic [2:0]          dbg_state
);

  lsu_state_e          state;
  logic                r_read;
  logic                r_unsigned;
  lsu_size_e           r_size;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wmask;
  logic [INFO_W-1:0]   r_info;
  logic [DATA_W-1:0]   r_data;

  logic                accept;
  logic                excp_in;
  lsu_size_e           req_size;
  logic [DATA_W-1:0]   load_data;
  logic [INFO_W-1:0]   err_bits;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid and payload hold steady until that edge.
  assign agu2lsu_ready = (state == ST_IDLE) & ~rst;
  assign accept        = agu2lsu_valid & agu2lsu_ready & ~agu2lsu_cancel & ~flush;
  assign excp_in       = agu2lsu_info[EXCP_W-1:0] != '0;

  assign bus_cmd_valid = (state == ST_CMD);
  assign bus_cmd_read  = r_read;
  assign bus_cmd_addr  = r_addr;
  assign bus_cmd_wdata = r_wdata;
  assign bus_cmd_wmask = r_wmask;
  assign lsu2wb_valid  = (state == ST_WB);
  assign lsu2wb_data   = r_data;
  assign lsu2wb_info   = r_info;
  assign dbg_state     = state;

  always_comb begin
    req_size = SZ_WORD;
    if (agu2lsu_byte_access)       req_size = SZ_BYTE;
    else if (agu2lsu_short_access) req_size = SZ_SHORT;
  end

  always_comb begin
    err_bits = '0;
    if (r_read) err_bits[EXCP_LD_FAULT] = 1'b1;
    else        err_bits[EXCP_ST_FAULT] = 1'b1;
  end

  hicore_lsu_align #(.DATA_W(DATA_W)) u_align (
    .rdata       (bus_rsp_rdata),
    .addr_lo     (r_addr[1:0]),
    .size        (r_size),
    .is_unsigned (r_unsigned),
    .data        (load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      r_read     <= 1'b0;
      r_unsigned <= 1'b0;
      r_size     <= SZ_BYTE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wmask    <= '0;
      r_info     <= '0;
      r_data     <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          r_read     <= agu2lsu_read;
          r_unsigned <= agu2lsu_unsigned;
          r_size     <= req_size;
          r_addr     <= agu2lsu_addr;
          r_wdata    <= agu2lsu_wdata;
          r_wmask    <= agu2lsu_wmask;
          r_info     <= agu2lsu_info;
          r_data     <= '0;
          state      <= excp_in ? ST_WB : ST_CMD;
        end
        // A command accepted in the flush cycle still owes a response.
        ST_CMD: if (flush) state <= bus_cmd_ready ? ST_DRAIN : ST_IDLE;
                else if (bus_cmd_ready) state <= ST_RSP;
        ST_RSP: if (flush) state <= bus_rsp_valid ? ST_IDLE : ST_DRAIN;
                else if (bus_rsp_valid) begin
                  if (bus_rsp_err) begin
                    r_data <= '0;
                    r_info <= r_info | err_bits;
                  end else begin
                    r_data <= r_read ? load_data : '0;
                  end
                  state <= ST_WB;
                end
        ST_DRAIN: if (bus_rsp_valid) state <= ST_IDLE;
        ST_WB: if (flush || lsu2wb_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hicore_lsu.sv
// Bench for hicore_lsu: directed corner cases plus random loads/stores, with
// writebacks checked by a scoreboard against an arithmetic reference model.
module tb_hicore_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        agu2lsu_valid = 0, agu2lsu_cancel = 0, agu2lsu_read = 0, agu2lsu_unsigned = 0;
  logic        agu2lsu_word_access = 0, agu2lsu_short_access = 0, agu2lsu_byte_access = 0;
  logic [31:0] agu2lsu_addr = 0, agu2lsu_wdata = 0;
  logic [3:0]  agu2lsu_wmask = 0;
  logic [63:0] agu2lsu_info = 0;
  logic        agu2lsu_ready;
  logic        bus_cmd_valid, bus_cmd_read;
  logic        bus_cmd_ready = 0;
  logic [31:0] bus_cmd_addr, bus_cmd_wdata;
  logic [3:0]  bus_cmd_wmask;
  logic        bus_rsp_valid = 0, bus_rsp_err = 0;
  logic [31:0] bus_rsp_rdata = 0;
  logic        lsu2wb_valid, lsu2wb_ready;
  logic [31:0] lsu2wb_data;
  logic [63:0] lsu2wb_info;
  logic        flush = 0;
  logic [2:0]  dbg_state;

  logic        wb_rand = 1'b1, wb_force = 1'b0, wb_rnd = 1'b0;
  assign lsu2wb_ready = wb_rand ? wb_rnd : wb_force;

  logic [95:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  hicore_lsu dut (
    .clk(clk), .rst(rst),
    .agu2lsu_valid(agu2lsu_valid), .agu2lsu_ready(agu2lsu_ready),
    .agu2lsu_cancel(agu2lsu_cancel), .agu2lsu_read(agu2lsu_read),
    .agu2lsu_unsigned(agu2lsu_unsigned), .agu2lsu_word_access(agu2lsu_word_access),
    .agu2lsu_short_access(agu2lsu_short_access), .agu2lsu_byte_access(agu2lsu_byte_access),
    .agu2lsu_addr(agu2lsu_addr), .agu2lsu_wdata(agu2lsu_wdata),
    .agu2lsu_wmask(agu2lsu_wmask), .agu2lsu_info(agu2lsu_info),
    .bus_cmd_valid(bus_cmd_valid), .bus_cmd_ready(bus_cmd_ready),
    .bus_cmd_read(bus_cmd_read), .bus_cmd_addr(bus_cmd_addr),
    .bus_cmd_wdata(bus_cmd_wdata), .bus_cmd_wmask(bus_cmd_wmask),
    .bus_rsp_valid(bus_rsp_valid), .bus_rsp_err(bus_rsp_err),
    .bus_rsp_rdata(bus_rsp_rdata),
    .lsu2wb_valid(lsu2wb_valid), .lsu2wb_ready(lsu2wb_ready),
    .lsu2wb_data(lsu2wb_data), .lsu2wb_info(lsu2wb_info),
    .flush(flush), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1 wb_rnd = 1'($urandom_range(0, 1));
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: pick the addressed byte/short with plain arithmetic.
  function automatic logic [31:0] ref_load(logic [31:0] word, int off, int sz, bit uns);
    longint v;
    v = longint'(word >> (8 * off));
    if (sz == 1) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = longint'(word);
    end
    return v[31:0];
  endfunction

  // Monitor: pops the scoreboard on each writeback handshake.
  logic        held = 1'b0;
  logic [95:0] held_v;
  logic [95:0] e;
  always @(negedge clk) begin
    if (!rst && lsu2wb_valid) begin
      if (held) begin
        chk("wb_stable_data", 64'(lsu2wb_data), 64'(held_v[31:0]));
        chk("wb_stable_info", lsu2wb_info, held_v[95:32]);
      end
      if (lsu2wb_ready) begin
        held = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_wb: got data %h info %h expected none", lsu2wb_data, lsu2wb_info);
        end else begin
          e = exp_q.pop_front();
          chk("wb_data", 64'(lsu2wb_data), 64'(e[31:0]));
          chk("wb_info", lsu2wb_info, e[95:32]);
        end
      end else begin
        held   = 1'b1;
        held_v = {lsu2wb_info, lsu2wb_data};
      end
    end else begin
      held = 1'b0;
    end
  end

  // Driver tasks
  task automatic send_req(input bit rd, input bit uns, input int sz, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask, input logic [63:0] info);
    bit ok = 0;
    int n = 0;
    agu2lsu_valid        = 1'b1;
    agu2lsu_read         = rd;
    agu2lsu_unsigned     = uns;
    agu2lsu_byte_access  = (sz == 1);
    agu2lsu_short_access = (sz == 2);
    agu2lsu_word_access  = (sz == 4);
    agu2lsu_addr         = addr;
    agu2lsu_wdata        = wdata;
    agu2lsu_wmask        = wmask;
    agu2lsu_info         = info;
    while (!ok && n < 50) begin
      @(negedge clk);
      ok = agu2lsu_ready;
      n++;
    end
    if (!ok) chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk);
    #1 agu2lsu_valid = 1'b0;
  endtask

  task automatic bus_complete(input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wmask, input int cmd_dly, input int rsp_dly,
                              input logic [31:0] rdata, input bit err);
    for (int k = 0; k <= cmd_dly; k++) begin
      bus_cmd_ready = (k == cmd_dly);
      @(negedge clk);
      chk("cmd_valid", 64'(bus_cmd_valid), 64'd1);
      chk("cmd_addr", 64'(bus_cmd_addr), 64'(addr));
      chk("cmd_fields", {27'd0, bus_cmd_read, bus_cmd_wmask, bus_cmd_wdata}, {27'd0, rd, wmask, wdata});
      @(posedge clk);
      #1;
    end
    bus_cmd_ready = 1'b0;
    repeat (rsp_dly) begin
      @(posedge clk);
      #1;
    end
    bus_rsp_valid = 1'b1;
    bus_rsp_rdata = rdata;
    bus_rsp_err   = err;
    @(posedge clk);
    #1;
    bus_rsp_valid = 1'b0;
    bus_rsp_err   = 1'b0;
    bus_rsp_rdata = $urandom;
  endtask

  task automatic wait_wb_done();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) chk("wb_timeout", 64'(exp_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input bit rd, input bit uns, input int sz, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wmask, input logic [63:0] info,
                        input logic [31:0] rdata, input bit err, input int cmd_dly, input int rsp_dly);
    logic [63:0] exp_info;
    logic [31:0] exp_data;
    if (info[15:0] != 16'h0) begin
      exp_q.push_back({info, 32'h0});
      send_req(rd, uns, sz, addr, wdata, wmask, info);
      @(negedge clk);
      chk("excp_no_cmd", 64'(bus_cmd_valid), 64'd0);
      chk("excp_wb_valid", 64'(lsu2wb_valid), 64'd1);
    end else begin
      exp_info = info;
      if (err) exp_info = info | (64'd1 << (rd ? 5 : 7));
      exp_data = (!rd || err) ? 32'h0 : ref_load(rdata, int'(addr % 4), sz, uns);
      exp_q.push_back({exp_info, exp_data});
      send_req(rd, uns, sz, addr, wdata, wmask, info);
      bus_complete(rd, addr, wdata, wmask, cmd_dly, rsp_dly, rdata, err);
    end
    wait_wb_done();
  endtask

  // Stimulus
  initial begin
    int sz;
    logic [63:0] info;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 64'(agu2lsu_ready), 64'd0);
    chk("rst_cmd_valid", 64'(bus_cmd_valid), 64'd0);
    chk("rst_wb_valid", 64'(lsu2wb_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(agu2lsu_ready), 64'd1);
    chk("post_rst_wb_data", 64'(lsu2wb_data), 64'd0);
    chk("post_rst_wb_info", lsu2wb_info, 64'd0);
    chk("post_rst_cmd_addr", 64'(bus_cmd_addr), 64'd0);
    @(posedge clk);
    #1;

    do_req(1, 0, 1, 32'h1003, 32'h0, 4'h0, 64'hABCD_0000_1234_0000, 32'h8011_2233, 0, 0, 1);
    do_req(1, 1, 2, 32'h1002, 32'h0, 4'h0, 64'h0000_0001_0000_0000, 32'h8001_0000, 0, 1, 0);
    do_req(0, 0, 4, 32'h2000, 32'hDEAD_BEEF, 4'hF, 64'h1111_2222_3333_0000, 32'h5555_5555, 0, 3, 2);
    do_req(1, 0, 4, 32'h3000, 32'h0, 4'h0, 64'h0000_0000_7777_0010, 32'h1234_5678, 0, 0, 0);
    do_req(1, 0, 4, 32'h4004, 32'h0, 4'h0, 64'h0000_0000_0000_0000, 32'hCAFE_F00D, 1, 1, 1);
    do_req(0, 0, 1, 32'h4005, 32'h0000_AA00, 4'h2, 64'h0000_0000_0000_0000, 32'h0, 1, 0, 0);

    // Flush in RSP, response two cycles later is drained.
    wb_rand = 1'b0;
    wb_force = 1'b0;
    send_req(1, 0, 4, 32'h5000, 32'h0, 4'h0, 64'h0);
    bus_cmd_ready = 1'b1;
    @(posedge clk);
    #1 bus_cmd_ready = 1'b0;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_rsp_drain", 64'(dbg_state), 64'd3);
    chk("flush_rsp_not_ready", 64'(agu2lsu_ready), 64'd0);
    @(posedge clk);
    #1 bus_rsp_valid = 1'b1;
    bus_rsp_rdata = 32'h1357_9BDF;
    @(negedge clk);
    chk("flush_rsp_no_wb", 64'(lsu2wb_valid), 64'd0);
    @(posedge clk);
    #1 bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_ready_after", 64'(agu2lsu_ready), 64'd1);
    chk("flush_rsp_no_wb2", 64'(lsu2wb_valid), 64'd0);

    // Flush in CMD while the bus accepts: the response must be drained.
    @(posedge clk);
    #1;
    send_req(0, 0, 4, 32'h5100, 32'h1, 4'hF, 64'h0);
    bus_cmd_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1 bus_cmd_ready = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_cmd_drain", 64'(dbg_state), 64'd3);
    bus_rsp_valid = 1'b1;
    @(posedge clk);
    #1 bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("drain_to_idle", 64'(dbg_state), 64'd0);

    // Flush in WB drops the writeback.
    @(posedge clk);
    #1;
    send_req(1, 0, 4, 32'h5200, 32'h0, 4'h0, 64'h0);
    bus_complete(1, 32'h5200, 32'h0, 4'h0, 0, 0, 32'h2468_ACE0, 0);
    @(negedge clk);
    chk("wb_before_flush", 64'(lsu2wb_valid), 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_wb_dropped", 64'(lsu2wb_valid), 64'd0);
    chk("flush_wb_ready", 64'(agu2lsu_ready), 64'd1);

    // Reset while holding a writeback.
    @(posedge clk);
    #1;
    send_req(1, 0, 4, 32'h5300, 32'h0, 4'h0, 64'h0000_0000_ABCD_0000);
    bus_complete(1, 32'h5300, 32'h0, 4'h0, 0, 0, 32'h0F0F_0F0F, 0);
    @(negedge clk);
    chk("wb_before_rst", 64'(lsu2wb_valid), 64'd1);
    rst = 1'b1;
    #1 chk("rst_cycle_ready", 64'(agu2lsu_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_wb_valid_low", 64'(lsu2wb_valid), 64'd0);
    chk("rst_state_idle", 64'(dbg_state), 64'd0);
    chk("rst_wb_data_zero", 64'(lsu2wb_data), 64'd0);

    // Cancelled request and a stray response in IDLE cause no activity.
    @(posedge clk);
    #1 agu2lsu_valid = 1'b1;
    agu2lsu_cancel = 1'b1;
    bus_rsp_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("cancel_no_cmd", 64'(bus_cmd_valid), 64'd0);
      chk("cancel_idle", 64'(dbg_state), 64'd0);
      @(posedge clk);
      #1;
    end
    agu2lsu_valid = 1'b0;
    agu2lsu_cancel = 1'b0;
    bus_rsp_valid = 1'b0;
    @(negedge clk);
    chk("stray_rsp_no_wb", 64'(lsu2wb_valid), 64'd0);
    @(posedge clk);
    #1;

    // Random traffic
    wb_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0: sz = 1;
        1: sz = 2;
        default: sz = 4;
      endcase
      info = {$urandom, $urandom};
      info[15:0] = ($urandom_range(0, 7) == 0) ? (16'h1 << ($urandom_range(0, 1) ? 4 : 6)) : 16'h0;
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), sz, $urandom, $urandom,
             4'($urandom_range(0, 15)), info, $urandom, ($urandom_range(0, 5) == 0),
             $urandom_range(0, 3), $urandom_range(0, 3));
    end

    repeat (5) @(posedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
